// File: rtl/vga_digit_ctrl_if.sv
// rtl/vga_digit_ctrl_if.sv - value load, raster position and decoder-side outputs of vga_digit_ctrl
interface vga_digit_ctrl_if;
  logic [13:0] value;
  logic        value_valid;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        video_on;
  logic [3:0]  num;
  logic [2:0]  seg_idx;
  logic        seg_hit;
  logic        busy;

  modport master (
    output value, value_valid, h_cnt, v_cnt, video_on,
    input  num, seg_idx, seg_hit, busy
  );

  modport slave (
    input  value, value_valid, h_cnt, v_cnt, video_on,
    output num, seg_idx, seg_hit, busy
  );
endinterface

// File: rtl/vga_digit_ctrl.sv
// rtl/vga_digit_ctrl.sv - four-digit seven-segment raster readout with sequential BCD and frame-synced commit
// Optional macro VGA_DIGIT_LZB_EN enables leading zero blanking of digits 3..1.
module vga_digit_ctrl #(
  parameter logic [9:0] X0      = 10'd240,
  parameter logic [9:0] Y0      = 10'd200,
  parameter logic [9:0] DIGIT_W = 10'd32,
  parameter logic [9:0] DIGIT_H = 10'd48,
  parameter logic [9:0] GAP     = 10'd8,
  parameter logic [9:0] SEG_T   = 10'd6
) (
  input  logic            clk,
  input  logic            rst,
  vga_digit_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, WAIT_FRAME} state_t;

  state_t          state_q, state_d;
  logic [13:0]     shift_q, shift_d;
  logic [15:0]     bcd_q, bcd_d, bcd_adj;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic [3:0]      num_q, num_d;
  logic [2:0]      seg_idx_q, seg_idx_d;
  logic            seg_hit_q, seg_hit_d;
  logic            frame_start;

  assign frame_start = (bus.h_cnt == 10'd0) && (bus.v_cnt == 10'd0);

  function automatic logic [9:0] box_x(input logic [1:0] k);
    return X0 + {8'd0, 2'd3 - k} * (DIGIT_W + GAP);
  endfunction

  // Double-dabble correction applied before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    // A load in any state restarts conversion; it also beats a pending commit.
    if (bus.value_valid) begin
      shift_d = bus.value;
      cnt_d   = 4'd0;
      if (bus.value > 14'd9999) begin
        bcd_d   = 16'hAAAA;
        state_d = WAIT_FRAME;
      end else begin
        bcd_d   = 16'd0;
        state_d = CONV;
      end
    end else begin
      case (state_q)
        CONV: begin
          bcd_d   = {bcd_adj[14:0], shift_q[13]};
          shift_d = {shift_q[12:0], 1'b0};
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd13) begin
            state_d = WAIT_FRAME;
          end
        end
        WAIT_FRAME: begin
          if (frame_start) begin
            disp_d  = bcd_q;
            state_d = IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  logic       in_y;
  logic       sel_valid;
  logic [1:0] sel;
  logic [9:0] lx, ly;
  logic [3:0] lead_zero;
  logic [2:0] idx;
  logic       on_seg;

  always_comb begin
    in_y      = (bus.v_cnt >= Y0) && (bus.v_cnt < Y0 + DIGIT_H);
    sel_valid = 1'b0;
    sel       = 2'd0;
    lx        = 10'd0;
    ly        = bus.v_cnt - Y0;
    for (int k = 0; k < 4; k++) begin
      if (in_y && bus.video_on && (bus.h_cnt >= box_x(2'(k))) &&
          (bus.h_cnt < box_x(2'(k)) + DIGIT_W)) begin
        sel_valid = 1'b1;
        sel       = 2'(k);
        lx        = bus.h_cnt - box_x(2'(k));
      end
    end

`ifdef VGA_DIGIT_LZB_EN
    lead_zero[3] = (disp_q[3] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp_q[2] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp_q[1] == 4'd0);
    lead_zero[0] = 1'b0;
`else
    lead_zero = 4'b0000;
`endif

    on_seg = 1'b1;
    idx    = 3'd0;
    if (ly < SEG_T) begin
      idx = 3'd0;
    end else if (ly >= DIGIT_H - SEG_T) begin
      idx = 3'd3;
    end else if ((ly >= ((DIGIT_H - SEG_T) >> 1)) && (ly < ((DIGIT_H + SEG_T) >> 1))) begin
      idx = 3'd6;
    end else if (lx >= DIGIT_W - SEG_T) begin
      idx = (ly < (DIGIT_H >> 1)) ? 3'd1 : 3'd2;
    end else if (lx < SEG_T) begin
      idx = (ly < (DIGIT_H >> 1)) ? 3'd5 : 3'd4;
    end else begin
      on_seg = 1'b0;
    end

    num_d     = 4'd15;
    seg_idx_d = 3'd0;
    seg_hit_d = 1'b0;
    if (sel_valid && !lead_zero[sel]) begin
      num_d     = disp_q[sel];
      seg_hit_d = on_seg;
      seg_idx_d = on_seg ? idx : 3'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= 14'd0;
      bcd_q     <= 16'd0;
      cnt_q     <= 4'd0;
      disp_q    <= '0;
      num_q     <= 4'd0;
      seg_idx_q <= 3'd0;
      seg_hit_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      num_q     <= num_d;
      seg_idx_q <= seg_idx_d;
      seg_hit_q <= seg_hit_d;
    end
  end

  assign bus.num     = num_q;
  assign bus.seg_idx = seg_idx_q;
  assign bus.seg_hit = seg_hit_q;
  assign bus.busy    = (state_q != IDLE);
endmodule

// File: tb/tb_vga_digit_ctrl.sv
// tb/tb_vga_digit_ctrl.sv - scoreboard bench for vga_digit_ctrl
module tb_vga_digit_ctrl;
  localparam int X0 = 240, Y0 = 200, DW = 32, DH = 48, GAP = 8, ST = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vga_digit_ctrl_if bus();
  vga_digit_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [3:0] num;
    logic [2:0] idx;
    logic       hit;
  } pix_t;

  pix_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mdl_disp[4];
  pix_t last;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Segment masks, bit0=a .. bit6=g.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'h3F;  4'd1: return 7'h06;  4'd2: return 7'h5B;
      4'd3: return 7'h4F;  4'd4: return 7'h66;  4'd5: return 7'h6D;
      4'd6: return 7'h7D;  4'd7: return 7'h07;  4'd8: return 7'h7F;
      4'd9: return 7'h6F;  4'd10: return 7'h40;
      default: return 7'h00;
    endcase
  endfunction

  function automatic pix_t model_pix(input int h, input int v, input bit von);
    pix_t p;
    int   lx, ly, bx;
    bit   blank;
    p = '{num: 4'd15, idx: 3'd0, hit: 1'b0};
    if (!von || v < Y0 || v >= Y0 + DH) return p;
    for (int k = 3; k >= 0; k--) begin
      bx = X0 + (3 - k) * (DW + GAP);
      if (h >= bx && h < bx + DW) begin
        lx = h - bx;
        ly = v - Y0;
        blank = 1'b0;
`ifdef VGA_DIGIT_LZB_EN
        if (k > 0) begin
          blank = 1'b1;
          for (int j = 3; j >= k; j--) if (mdl_disp[j] != 0) blank = 1'b0;
        end
`endif
        if (blank) return p;
        p.num = 4'(mdl_disp[k]);
        p.hit = 1'b1;
        if (ly < ST)                                  p.idx = 3'd0;
        else if (ly >= DH - ST)                       p.idx = 3'd3;
        else if (ly >= (DH - ST) / 2 && ly < (DH + ST) / 2) p.idx = 3'd6;
        else if (lx >= DW - ST)                       p.idx = (ly < DH / 2) ? 3'd1 : 3'd2;
        else if (lx < ST)                             p.idx = (ly < DH / 2) ? 3'd5 : 3'd4;
        else begin
          p.hit = 1'b0;
          p.idx = 3'd0;
        end
      end
    end
    return p;
  endfunction

  task automatic pix(input int h, input int v, input bit von, input bit vv = 1'b0, input int val = 0);
    pix_t e;
    @(negedge clk);
    bus.h_cnt       = 10'(h);
    bus.v_cnt       = 10'(v);
    bus.video_on    = von;
    bus.value_valid = vv;
    bus.value       = 14'(val);
    sb_q.push_back(model_pix(h, v, von));
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    last = '{num: bus.num, idx: bus.seg_idx, hit: bus.seg_hit};
    check_eq($sformatf("num(%0d,%0d)", h, v), 32'(bus.num), 32'(e.num));
    check_eq($sformatf("seg_idx(%0d,%0d)", h, v), 32'(bus.seg_idx), 32'(e.idx));
    check_eq($sformatf("seg_hit(%0d,%0d)", h, v), 32'(bus.seg_hit), 32'(e.hit));
    bus.value_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) pix(1, 1, 1'b1);
  endtask

  task automatic set_model(input int d3, input int d2, input int d1, input int d0);
    mdl_disp[3] = d3; mdl_disp[2] = d2; mdl_disp[1] = d1; mdl_disp[0] = d0;
  endtask

  task automatic check_digits();
    for (int k = 3; k >= 0; k--) begin
      pix(X0 + (3 - k) * (DW + GAP) + 10, Y0 + 2, 1'b1);
      pix(X0 + (3 - k) * (DW + GAP) + 16, Y0 + 24, 1'b1);
    end
  endtask

  // Load, run the full 14 iterations, show that a frame at the 14th cycle is too early, then commit.
  task automatic load_and_commit(input int val, input int d3, input int d2, input int d1, input int d0);
    pix(5, 5, 1'b1, 1'b1, val);
    check_eq("busy_after_load", 32'(bus.busy), 32'd1);
    idle_cycles(13);
    pix(0, 0, 1'b1);
    check_eq("busy_no_early_commit", 32'(bus.busy), 32'd1);
    pix(0, 0, 1'b1);
    check_eq("busy_after_commit", 32'(bus.busy), 32'd0);
    set_model(d3, d2, d1, d0);
    check_digits();
  endtask

  initial begin
    rst = 1'b1;
    bus.value = 14'd0;
    bus.value_valid = 1'b0;
    bus.h_cnt = 10'd1;
    bus.v_cnt = 10'd1;
    bus.video_on = 1'b0;
    set_model(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_num", 32'(bus.num), 32'd0);
    check_eq("rst_seg_idx", 32'(bus.seg_idx), 32'd0);
    check_eq("rst_seg_hit", 32'(bus.seg_hit), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    pix(0, 0, 1'b1);
    check_eq("idle_frame_busy", 32'(bus.busy), 32'd0);
    pix(X0 + 10, Y0 + 2, 1'b1);
    check_eq("reset_digit3_a_num", 32'(last.num), 32'd0);
    check_eq("reset_digit3_a_hit", 32'(last.hit), 32'd1);
    check_digits();

    load_and_commit(1234, 1, 2, 3, 4);
    pix(X0 + 40 + 2, Y0 + 10, 1'b1);
    check_eq("digit2_f_idx", 32'(last.idx), 32'd5);
    begin
      logic [6:0] m;
      m = seg7(last.num);
      check_eq("digit2_f_masked", 32'(m[last.idx] & last.hit), 32'd0);
    end

    // Overflow skips conversion: commit on the very next frame.
    pix(5, 5, 1'b1, 1'b1, 12000);
    check_eq("ovf_busy", 32'(bus.busy), 32'd1);
    pix(0, 0, 1'b1);
    check_eq("ovf_commit_busy", 32'(bus.busy), 32'd0);
    set_model(10, 10, 10, 10);
    pix(X0 + 16, Y0 + 24, 1'b1);
    check_eq("dash_g_idx", 32'(last.idx), 32'd6);
    check_eq("dash_num", 32'(last.num), 32'd10);
    check_digits();

    // Restart on conversion cycle 5; 500 must never be committed.
    pix(5, 5, 1'b1, 1'b1, 500);
    idle_cycles(4);
    load_and_commit(9999, 9, 9, 9, 9);

    // Load coincident with frame start in IDLE does not commit that frame.
    pix(0, 0, 1'b1, 1'b1, 55);
    check_eq("coinc_busy", 32'(bus.busy), 32'd1);
    pix(0, 0, 1'b1);
    check_eq("coinc_busy2", 32'(bus.busy), 32'd1);
    idle_cycles(13);
    pix(0, 0, 1'b1);
    check_eq("coinc_commit_busy", 32'(bus.busy), 32'd0);
    set_model(0, 0, 5, 5);
    check_digits();

    load_and_commit(7, 0, 0, 0, 7);
    pix(X0 + 10, Y0 + 2, 1'b1);
`ifdef VGA_DIGIT_LZB_EN
    check_eq("lzb_digit3_num", 32'(last.num), 32'd15);
`else
    check_eq("nolzb_digit3_num", 32'(last.num), 32'd0);
`endif

    load_and_commit(1000, 1, 0, 0, 0);

    // Box boundaries and blanking conditions.
    pix(X0 + 31, Y0 + 47, 1'b1);
    pix(X0 + 32, Y0 + 2, 1'b1);
    pix(X0 + 39, Y0 + 2, 1'b1);
    pix(X0 - 1, Y0 + 2, 1'b1);
    pix(X0 + 10, Y0 - 1, 1'b1);
    pix(X0 + 10, Y0 + 48, 1'b1);
    pix(X0 + 151, Y0 + 30, 1'b1);
    pix(X0 + 152, Y0 + 30, 1'b1);
    pix(X0 + 10, Y0 + 2, 1'b0);
    pix(X0 + 16, Y0 + 12, 1'b1);
    pix(X0 + 28, Y0 + 30, 1'b1);

    // Reset mid-conversion clears everything and nothing commits afterwards.
    pix(5, 5, 1'b1, 1'b1, 777);
    idle_cycles(3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_busy", 32'(bus.busy), 32'd0);
    check_eq("midrst_num", 32'(bus.num), 32'd0);
    check_eq("midrst_hit", 32'(bus.seg_hit), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_model(0, 0, 0, 0);
    idle_cycles(16);
    pix(0, 0, 1'b1);
    check_eq("midrst_no_commit_busy", 32'(bus.busy), 32'd0);
    check_digits();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
